// File: rtl/analyzer_display_pkg.sv
// Shared display definitions for the analyzer plot renderers: window geometry
// defaults, grid pitch, RAM read latency and the frame-state encoding.
package analyzer_display_pkg;
  localparam int WIN_X0_DEF    = 100;
  localparam int WIN_Y0_DEF    = 40;
  localparam int WIN_W_DEF     = 405;
  localparam int WIN_H_DEF     = 256;
  localparam int SAMPLE_W_DEF  = 10;
  localparam int RD_LAT_DEF    = 2;
  localparam int GRID_STEP_DEF = 32;
  localparam int COORD_W       = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } frame_state_t;
endpackage

// File: rtl/waveform_plot_renderer_if.sv
// Read port between a plot renderer and its channel's waveform storage RAM.
interface waveform_plot_renderer_if #(
  parameter int SAMPLE_W = 10
);
  // read_enable high: the storage returns the sample at its current address
  // RD_LAT cycles after the pixel and advances one address per cycle; while
  // low the address returns to 0. There is no back-pressure.
  logic                read_enable;
  logic [SAMPLE_W-1:0] sample_q;

  modport master (output read_enable, input sample_q);
  modport slave  (input read_enable, output sample_q);
endinterface

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register used to line pixel attributes up with RAM data.
module pixel_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];
endmodule

// File: rtl/waveform_plot_renderer.sv
// Per-channel plot renderer: fetches one stored sample per window column and
// classifies each pixel as trace, grid or background, RD_LAT+1 cycles late.
module waveform_plot_renderer
  import analyzer_display_pkg::*;
#(
  parameter int WIN_X0    = WIN_X0_DEF,
  parameter int WIN_Y0    = WIN_Y0_DEF,
  parameter int WIN_W     = WIN_W_DEF,
  parameter int WIN_H     = WIN_H_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int GRID_STEP = GRID_STEP_DEF
) (
  input  logic                     VGA_CLK,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       hcount,
  input  logic [COORD_W-1:0]       vcount,
  input  logic                     video_on,
  waveform_plot_renderer_if.master ram,
  output logic                     trace_on,
  output logic                     grid_on,
  output logic                     video_on_d,
  output logic                     frame_done,
  output frame_state_t             state_dbg
);
  localparam int PIPE_W = 2 * COORD_W + 2;
  localparam logic [COORD_W-1:0] GRID_MASK = COORD_W'(GRID_STEP - 1);

  logic h_in, v_in, in_win;
  logic [COORD_W-1:0] col, row;

  assign h_in   = (hcount >= COORD_W'(WIN_X0)) && (hcount < COORD_W'(WIN_X0 + WIN_W));
  assign v_in   = (vcount >= COORD_W'(WIN_Y0)) && (vcount < COORD_W'(WIN_Y0 + WIN_H));
  assign in_win = h_in && v_in && video_on;
  assign col    = hcount - COORD_W'(WIN_X0);
  assign row    = vcount - COORD_W'(WIN_Y0);

  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic win_a, von_a;
  logic [COORD_W-1:0] col_a, row_a;

  assign pipe_in = {in_win, video_on, col, row};

  pixel_delay_line #(.DEPTH(RD_LAT), .WIDTH(PIPE_W)) u_align (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .data    (pipe_in),
    .delayed (pipe_out)
  );

  assign {win_a, von_a, col_a, row_a} = pipe_out;

  // Top 8 sample bits give the height; flip so sample 0 lands on the bottom row.
  logic [7:0] y_cur, y_prev, y_ref, y_lo, y_hi;
  logic trace_hit, grid_hit, last_a;

  assign y_cur     = 8'(WIN_H - 1) - ram.sample_q[SAMPLE_W-1 -: 8];
  assign y_ref     = (col_a == '0) ? y_cur : y_prev;
  assign y_lo      = (y_ref < y_cur) ? y_ref : y_cur;
  assign y_hi      = (y_ref < y_cur) ? y_cur : y_ref;
  assign trace_hit = (row_a >= {3'b000, y_lo}) && (row_a <= {3'b000, y_hi});
  assign grid_hit  = ((col_a & GRID_MASK) == '0) || ((row_a & GRID_MASK) == '0) ||
                     (col_a == COORD_W'(WIN_W - 1)) || (row_a == COORD_W'(WIN_H - 1));
  assign last_a    = (col_a == COORD_W'(WIN_W - 1)) && (row_a == COORD_W'(WIN_H - 1));

  logic read_en;
  assign ram.read_enable = read_en;

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      read_en    <= 1'b0;
      trace_on   <= 1'b0;
      grid_on    <= 1'b0;
      video_on_d <= 1'b0;
      y_prev     <= '0;
    end else begin
      read_en    <= in_win;
      trace_on   <= win_a && trace_hit;
      grid_on    <= win_a && grid_hit;
      video_on_d <= von_a;
      if (win_a) y_prev <= y_cur;
    end
  end

  // armed blocks a second frame_done until the beam has left the window rows.
  frame_state_t state;
  logic armed;

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      armed      <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (!v_in) armed <= 1'b1;
      case (state)
        IDLE:    if (win_a && armed) state <= ACTIVE;
        ACTIVE:  if (win_a && last_a) begin
                   state      <= DONE;
                   frame_done <= 1'b1;
                   armed      <= 1'b0;
                 end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_waveform_plot_renderer.sv
// Bench for waveform_plot_renderer: RAM model, line driver, pixel scoreboard.
module tb_waveform_plot_renderer;
  import analyzer_display_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic VGA_CLK = 1'b0;
  logic reset   = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  logic [10:0] hcount   = '0;
  logic [10:0] vcount   = '0;
  logic        video_on = 1'b0;
  logic trace_on, grid_on, video_on_d, frame_done;
  frame_state_t state_dbg;

  waveform_plot_renderer_if #(.SAMPLE_W(10)) ram ();

  waveform_plot_renderer dut (
    .VGA_CLK    (VGA_CLK),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .video_on   (video_on),
    .ram        (ram),
    .trace_on   (trace_on),
    .grid_on    (grid_on),
    .video_on_d (video_on_d),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // storage model: registered read, address restarts whenever read_enable is low
  logic [9:0] mem [0:404];
  int addr = 0;
  initial ram.sample_q = '0;
  always @(posedge VGA_CLK) begin
    if (ram.read_enable) begin
      ram.sample_q <= (addr < 405) ? mem[addr] : 10'd0;
      addr <= addr + 1;
    end else begin
      addr <= 0;
    end
  end

  int cyc = 0;
  always @(posedge VGA_CLK) cyc <= cyc + 1;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           exp_tag_q[$];
  logic         re_q[$];
  int           re_tag_q[$];
  int re_cnt = 0;
  int fd_cnt = 0;
  logic m_active = 1'b0;
  logic m_armed  = 1'b1;

  task automatic check(input string tag, input integer got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge VGA_CLK) begin
    if (ram.read_enable) re_cnt++;
    if (frame_done) fd_cnt++;
    if (re_tag_q.size() > 0 && re_tag_q[0] == cyc - 1) begin
      check("read_enable", ram.read_enable, re_q[0]);
      void'(re_q.pop_front());
      void'(re_tag_q.pop_front());
    end
    if (exp_tag_q.size() > 0 && exp_tag_q[0] == cyc - 3) begin
      check("pixel{trace,grid,vod,fd}", {trace_on, grid_on, video_on_d, frame_done}, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_tag_q.pop_front());
    end
  end

  function automatic logic [7:0] ycol(input int c);
    int s;
    s = mem[c] >> 2;
    return 8'(255 - s);
  endfunction

  // driver
  task automatic drive(input int h, input int v, input logic vo);
    int col, row;
    logic win, tr, gr, fd;
    logic [7:0] a, b, lo, hi;
    @(posedge VGA_CLK); #1;
    hcount = 11'(h); vcount = 11'(v); video_on = vo;
    col = h - 100;
    row = v - 40;
    win = vo && col >= 0 && col < 405 && row >= 0 && row < 256;
    if (!(row >= 0 && row < 256)) m_armed = 1'b1;
    tr = 1'b0; gr = 1'b0; fd = 1'b0;
    if (win) begin
      b  = ycol(col);
      a  = (col == 0) ? b : ycol(col - 1);
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      tr = (row >= int'(lo)) && (row <= int'(hi));
      gr = (col % 32 == 0) || (row % 32 == 0) || col == 404 || row == 255;
      if (!m_active && m_armed) m_active = 1'b1;
      else if (m_active && col == 404 && row == 255) begin
        fd = 1'b1; m_active = 1'b0; m_armed = 1'b0;
      end
    end
    exp_q.push_back({tr, gr, vo, fd});
    exp_tag_q.push_back(cyc);
    re_q.push_back(win);
    re_tag_q.push_back(cyc);
  endtask

  task automatic drive_line(input int v, input logic vo);
    re_cnt = 0;
    for (int h = 96; h < 510; h++) drive(h, v, vo);
    check("re_count", re_cnt, (vo && v >= 40 && v < 296) ? 405 : 0);
  endtask

  task automatic fill_const(input logic [9:0] s);
    for (int c = 0; c < 405; c++) mem[c] = s;
  endtask

  task automatic reset_mid_line(input int v);
    for (int h = 96; h < 200; h++) drive(h, v, 1'b1);
    @(posedge VGA_CLK); #1;
    reset = 1'b0; hcount = 11'd200; vcount = 11'(v); video_on = 1'b1;
    while (exp_tag_q.size() > 0 && exp_tag_q[$] > cyc - 3) begin
      void'(exp_q.pop_back()); void'(exp_tag_q.pop_back());
    end
    while (re_tag_q.size() > 0 && re_tag_q[$] > cyc - 1) begin
      void'(re_q.pop_back()); void'(re_tag_q.pop_back());
    end
    @(posedge VGA_CLK); #1;
    hcount = 11'd201; video_on = 1'b0;
    @(negedge VGA_CLK);
    check("rst_read_enable", ram.read_enable, 0);
    check("rst_trace_on", trace_on, 0);
    check("rst_grid_on", grid_on, 0);
    check("rst_video_on_d", video_on_d, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    m_active = 1'b0;
    m_armed  = 1'b1;
    @(posedge VGA_CLK); #1;
    reset = 1'b1;
  endtask

  initial begin
    fill_const(10'd512);
    repeat (3) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    check("init_read_enable", ram.read_enable, 0);
    check("init_trace_on", trace_on, 0);
    check("init_grid_on", grid_on, 0);
    check("init_video_on_d", video_on_d, 0);
    check("init_frame_done", frame_done, 0);
    check("init_state", int'(state_dbg), int'(IDLE));
    @(posedge VGA_CLK); #1;
    reset = 1'b1;

    // constant mid-scale sample: flat trace on row 127, one frame_done
    fd_cnt = 0;
    drive_line(300, 1'b1);
    drive_line(40, 1'b1);
    drive_line(41, 1'b1);
    drive_line(167, 1'b1);
    drive_line(295, 1'b1);
    check("fd_count_const", fd_cnt, 1);

    // PWM 0/1023 every 20 columns
    for (int c = 0; c < 405; c++) mem[c] = ((c / 20) % 2 == 1) ? 10'd1023 : 10'd0;
    fd_cnt = 0;
    drive_line(10, 1'b1);
    drive_line(40, 1'b1);
    drive_line(100, 1'b1);
    drive_line(295, 1'b1);
    check("fd_count_pwm", fd_cnt, 1);

    // grid rows with the trace parked on row 127
    fill_const(10'd512);
    fd_cnt = 0;
    drive_line(10, 1'b1);
    for (int r = 0; r < 256; r += 32) drive_line(40 + r, 1'b1);
    drive_line(40 + 127, 1'b1);
    drive_line(40 + 255, 1'b1);
    check("fd_count_grid", fd_cnt, 1);

    // random samples with a full-scale jump across the line boundary
    for (int c = 0; c < 405; c++) mem[c] = 10'($urandom_range(0, 1023));
    mem[404] = 10'd1023;
    mem[0]   = 10'd0;
    fd_cnt = 0;
    drive_line(50, 1'b1);
    drive_line(51, 1'b1);
    drive_line(60, 1'b0);
    check("fd_count_unarmed", fd_cnt, 0);

    // reset in the middle of a line, then a clean frame
    reset_mid_line(70);
    fill_const(10'd512);
    fd_cnt = 0;
    drive_line(10, 1'b1);
    drive_line(40, 1'b1);
    drive_line(295, 1'b1);
    drive_line(400, 1'b1);
    check("fd_count_after_reset", fd_cnt, 1);

    for (int i = 0; i < 5; i++) drive(600, 500, 1'b0);
    repeat (5) @(posedge VGA_CLK);
    @(negedge VGA_CLK);
    check("scoreboard_drained", exp_q.size() + re_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
